// File: rtl/uart_rx_sink_pkg.sv
// Shared definitions for the UART receive sink: FSM state encodings,
// default parameter values and a small parity helper.
package uart_rx_sink_pkg;

  // Default pclk cycles per UART bit and default receive FIFO depth.
  localparam int DEFAULT_BAUD_DIV   = 868;
  localparam int DEFAULT_FIFO_DEPTH = 16;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // Even parity: data bits plus parity bit must hold an even number of ones.
  function automatic logic even_parity_ok(input logic [7:0] data, input logic par_bit);
    return ((^data) == par_bit);
  endfunction

endpackage

// File: rtl/uart_sink_fifo.sv
// Byte FIFO with first-word-fall-through head register.
// The storage array has no reset and is read through a registered port,
// so rd_data is a register that always holds the current head; it keeps
// its last value while the FIFO is empty.
module uart_sink_fifo
  import uart_rx_sink_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                     pclk,
  input  logic                     prst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] rd_ptr_next;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic [7:0]    rd_data_reg;
  logic          do_wr;
  logic          do_rd;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_CNT);
  assign count   = count_reg;
  assign rd_data = rd_data_reg;

  // A pop on empty is ignored; a push on full is only taken alongside a pop.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Next read pointer and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    rd_ptr_next = do_rd ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
    count_next  = count_reg;
    if (do_wr && !do_rd) begin
      count_next = count_reg + (AW + 1)'(1);
    end else if (!do_wr && do_rd) begin
      count_next = count_reg - (AW + 1)'(1);
    end
  end

  // Storage write port.
  always_ff @(posedge pclk) begin
    if (do_wr) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge pclk) begin
    if (prst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Head register: fetch the entry at the next read pointer, bypassing the
  // write data when that entry is being written in this same cycle.
  always_ff @(posedge pclk) begin
    if (prst) begin
      rd_data_reg <= '0;
    end else if (count_next != '0) begin
      if (do_wr && (wr_ptr_reg == rd_ptr_next)) begin
        rd_data_reg <= wr_data;
      end else begin
        rd_data_reg <= mem[rd_ptr_next];
      end
    end
  end

endmodule

// File: rtl/uart_rx_sink.sv
// UART receiver feeding a FWFT byte FIFO with CTS flow control.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit between
// the data bits and the stop bit; without it par_err is tied low.
module uart_rx_sink
  import uart_rx_sink_pkg::*;
#(
  parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                          pclk,
  input  logic                          prst,
  input  logic                          uart_rx_in,
  output logic                          uart_cts,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          ovf_err,
  output logic                          par_err
);

  localparam int TW = $clog2(BAUD_DIV + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] FULL_BIT  = TW'(BAUD_DIV);
  localparam logic [TW-1:0] HALF_BIT  = TW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] CTS_LIMIT = CW'(FIFO_DEPTH - 2);

  logic          rx_meta_reg;
  logic          rx_sync_reg;
  logic          rx_prev_reg;
  logic          fall_edge;
  rx_state_t     state_reg;
  logic [TW-1:0] timer_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          tick;
  logic          par_bad;
  logic          push_req;
  logic          frame_err_reg;
  logic          ovf_err_reg;
  logic          cts_reg;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge pclk) begin
    if (prst) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= uart_rx_in;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
    end
  end

  // Only a genuine high-to-low transition arms the receiver, so after a
  // framing error the line has to go back high before a new frame starts.
  assign fall_edge = rx_prev_reg && !rx_sync_reg;

  // The timer counts down from its load value; a sample point is the cycle
  // where it reads 1, giving exactly load-value cycles between samples.
  assign tick = (timer_reg == TW'(1));

  // A byte is pushed at the stop sample when the stop bit is good and the
  // parity (if present) matched.
  assign push_req = (state_reg == ST_STOP) && tick && rx_sync_reg && !par_bad;

`ifdef UART_RX_PARITY_EN
  logic par_bad_reg;
  logic par_err_reg;

  assign par_bad = par_bad_reg;
  assign par_err = par_err_reg;
`else
  assign par_bad = 1'b0;
  assign par_err = 1'b0;
`endif

  // Receiver FSM: start validation, LSB-first data, optional parity, stop.
  always_ff @(posedge pclk) begin
    if (prst) begin
      state_reg     <= ST_IDLE;
      timer_reg     <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      frame_err_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_reg   <= 1'b0;
      par_err_reg   <= 1'b0;
`endif
    end else begin
      frame_err_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_reg   <= 1'b0;
`endif
      case (state_reg)
        ST_IDLE: begin
          if (fall_edge) begin
            timer_reg <= HALF_BIT;
            state_reg <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            if (!rx_sync_reg) begin
              timer_reg   <= FULL_BIT;
              bit_idx_reg <= '0;
              state_reg   <= ST_DATA;
            end else begin
              state_reg <= ST_IDLE;
            end
          end else begin
            timer_reg <= timer_reg - TW'(1);
          end
        end
        ST_DATA: begin
          if (tick) begin
            shift_reg   <= {rx_sync_reg, shift_reg[7:1]};
            timer_reg   <= FULL_BIT;
            bit_idx_reg <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_reg <= ST_PARITY;
`else
              state_reg <= ST_STOP;
`endif
            end
          end else begin
            timer_reg <= timer_reg - TW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            par_bad_reg <= !even_parity_ok(shift_reg, rx_sync_reg);
            timer_reg   <= FULL_BIT;
            state_reg   <= ST_STOP;
          end else begin
            timer_reg <= timer_reg - TW'(1);
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            frame_err_reg <= !rx_sync_reg;
`ifdef UART_RX_PARITY_EN
            par_err_reg   <= par_bad_reg;
`endif
            state_reg     <= ST_IDLE;
          end else begin
            timer_reg <= timer_reg - TW'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Overflow pulse and registered clear-to-send derived from occupancy.
  always_ff @(posedge pclk) begin
    if (prst) begin
      ovf_err_reg <= 1'b0;
      cts_reg     <= 1'b1;
    end else begin
      ovf_err_reg <= push_req && fifo_full && !rd_en;
      cts_reg     <= (fifo_count < CTS_LIMIT);
    end
  end

  assign frame_err = frame_err_reg;
  assign ovf_err   = ovf_err_reg;
  assign uart_cts  = cts_reg;

  uart_sink_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .pclk    (pclk),
    .prst    (prst),
    .wr_en   (push_req),
    .wr_data (shift_reg),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_sink.sv
// Self-checking bench for uart_rx_sink (BAUD_DIV=16, FIFO_DEPTH=4).
// Follows UART_RX_PARITY_EN when the bundle is built with it.
module tb_uart_rx_sink;

  localparam int BD = 16;
  localparam int FD = 4;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // Line falls at negedge 0; two synchronizer flops plus the edge-history
  // flop put the detected start 3 cycles later, then half a bit to the start
  // sample and one full bit per following sample up to the stop bit.
  localparam int STOP_EDGE = 3 + BD / 2 + (NB - 1) * BD;

  logic       pclk = 1'b0;
  logic       prst;
  logic       uart_rx_in;
  logic       uart_cts;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       fifo_empty;
  logic       fifo_full;
  logic [2:0] fifo_count;
  logic       frame_err;
  logic       ovf_err;
  logic       par_err;

  int n_assert = 0;
  int n_fail   = 0;
  int obs_frame = 0, obs_ovf = 0, obs_par = 0;
  int exp_frame = 0, exp_ovf = 0, exp_par = 0;
  logic [7:0] model_q[$];
  logic [7:0] last_head = 8'h00;

  uart_rx_sink #(.BAUD_DIV(BD), .FIFO_DEPTH(FD)) dut (
    .pclk       (pclk),
    .prst       (prst),
    .uart_rx_in (uart_rx_in),
    .uart_cts   (uart_cts),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .ovf_err    (ovf_err),
    .par_err    (par_err)
  );

  always #5 pclk = ~pclk;

  // Count every cycle each error output is high, sampled mid-cycle.
  always @(negedge pclk) begin
    if (frame_err) obs_frame++;
    if (ovf_err)   obs_ovf++;
    if (par_err)   obs_par++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare all observable state against the reference model.
  task automatic check_state(input string tag);
    check({tag, "_count"}, 32'(fifo_count), 32'(model_q.size()));
    check({tag, "_empty"}, 32'(fifo_empty), 32'(model_q.size() == 0));
    check({tag, "_full"},  32'(fifo_full),  32'(model_q.size() == FD));
    check({tag, "_cts"},   32'(uart_cts),   32'(model_q.size() < FD - 2));
    check({tag, "_frame"}, 32'(obs_frame),  32'(exp_frame));
    check({tag, "_ovf"},   32'(obs_ovf),    32'(exp_ovf));
    check({tag, "_par"},   32'(obs_par),    32'(exp_par));
    if (model_q.size() != 0) check({tag, "_head"}, 32'(rd_data), 32'(model_q[0]));
    else                     check({tag, "_hold"}, 32'(rd_data), 32'(last_head));
    $display("step %s: count=%0d head=%02h cts=%0b", tag, fifo_count, rd_data, uart_cts);
  endtask

  // What the receiver must do with one complete frame.
  task automatic apply_model(input logic [7:0] d, input bit stop_ok, input bit par_ok,
                             input bit popped);
    if (popped && model_q.size() != 0) last_head = model_q.pop_front();
    if (!stop_ok) exp_frame++;
    if (!par_ok)  exp_par++;
    if (stop_ok && par_ok) begin
      if (model_q.size() < FD) model_q.push_back(d);
      else                     exp_ovf++;
    end
  endtask

  // Serialize one frame, one negedge per loop pass. Optionally pulse rd_en
  // in the cycle of the stop sample, check FWFT latency, or abort early.
  task automatic drive_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok,
                             input bit pop_at_stop, input bit chk_lat, input int abort_at);
    logic [NB-1:0] bits;
`ifdef UART_RX_PARITY_EN
    bits = {stop_ok, (^d) ^ !par_ok, d, 1'b0};
`else
    bits = {stop_ok, d, 1'b0};
`endif
    @(negedge pclk);
    for (int c = 0; c < NB * BD; c++) begin
      if (c == abort_at) return;
      uart_rx_in = bits[c / BD];
      rd_en = pop_at_stop && (c == STOP_EDGE - 1);
      if (chk_lat && c == STOP_EDGE - 1) check("lat_empty_before", 32'(fifo_empty), 32'd1);
      if (chk_lat && c == STOP_EDGE) begin
        check("lat_empty_after", 32'(fifo_empty), 32'd0);
        check("lat_data_after",  32'(rd_data),    32'(d));
      end
      @(negedge pclk);
    end
    rd_en = 1'b0;
    uart_rx_in = 1'b1;
    repeat (4) @(negedge pclk);
    $display("frame %02h stop=%0b par_ok=%0b pop=%0b", d, stop_ok, par_ok, pop_at_stop);
  endtask

  task automatic pop_check(input string tag);
    @(negedge pclk);
    check({tag, "_pop"}, 32'(rd_data), 32'(model_q[0]));
    rd_en = 1'b1;
    @(negedge pclk);
    rd_en = 1'b0;
    last_head = model_q.pop_front();
  endtask

  task automatic empty_read(input string tag);
    @(negedge pclk);
    rd_en = 1'b1;
    @(negedge pclk);
    rd_en = 1'b0;
    @(negedge pclk);
    check({tag, "_count"}, 32'(fifo_count), 32'd0);
    check({tag, "_stable"}, 32'(rd_data), 32'(last_head));
  endtask

  task automatic do_reset();
    prst = 1'b1;
    uart_rx_in = 1'b1;
    rd_en = 1'b0;
    repeat (3) @(negedge pclk);
    prst = 1'b0;
    model_q.delete();
    last_head = 8'h00;
    repeat (3) @(negedge pclk);
  endtask

  initial begin
    logic [7:0] d;
    bit stop_ok, par_ok;
    int npop;
    string tag;

    prst = 1'b1;
    uart_rx_in = 1'b1;
    rd_en = 1'b0;
    do_reset();
    check_state("reset");
    check("reset_rd_data", 32'(rd_data), 32'h00);

    // Clean frame with exact FWFT latency.
    drive_frame(8'hA5, 1, 1, 0, 1, -1);
    apply_model(8'hA5, 1, 1, 0);
    check_state("a5");
    pop_check("a5");
    check_state("a5_popped");

    // Short low glitch on an idle line is a false start.
    @(negedge pclk);
    uart_rx_in = 1'b0;
    repeat (4) @(negedge pclk);
    uart_rx_in = 1'b1;
    repeat (40) @(negedge pclk);
    check_state("glitch");

    // Bad stop bit, then a good frame.
    drive_frame(8'h3C, 0, 1, 0, 0, -1);
    apply_model(8'h3C, 0, 1, 0);
    check_state("frame_err");
    drive_frame(8'h11, 1, 1, 0, 0, -1);
    apply_model(8'h11, 1, 1, 0);
    check_state("after_ferr");
    pop_check("x11");

    // Fill past capacity with no reads.
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i);
      drive_frame(d, 1, 1, 0, 0, -1);
      apply_model(d, 1, 1, 0);
      tag = $sformatf("fill%0d", i);
      check_state(tag);
    end
    for (int i = 0; i < FD; i++) pop_check("drain");
    check_state("drained");

    // Push coinciding with a pop on a full FIFO is accepted.
    for (int i = 1; i <= 4; i++) begin
      d = 8'(i);
      drive_frame(d, 1, 1, 0, 0, -1);
      apply_model(d, 1, 1, 0);
    end
    check_state("full_again");
    drive_frame(8'h05, 1, 1, 1, 0, -1);
    apply_model(8'h05, 1, 1, 1);
    check_state("push_pop_full");
    for (int i = 0; i < FD; i++) pop_check("drain2");
    empty_read("empty_rd");

    // Reset in the middle of data bit 3.
    drive_frame(8'h7E, 1, 1, 0, 0, 4 * BD + BD / 2);
    do_reset();
    check_state("mid_reset");
    drive_frame(8'h7E, 1, 1, 0, 0, -1);
    apply_model(8'h7E, 1, 1, 0);
    check_state("after_reset");
    pop_check("x7e");
`ifdef UART_RX_PARITY_EN
    drive_frame(8'h7E, 1, 0, 0, 0, -1);
    apply_model(8'h7E, 1, 0, 0);
    check_state("par_bad");
`endif

    // Randomized frames with random reads between them.
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      stop_ok = ($urandom_range(0, 4) != 0);
      par_ok = 1'b1;
`ifdef UART_RX_PARITY_EN
      par_ok = ($urandom_range(0, 3) != 0);
`endif
      drive_frame(d, stop_ok, par_ok, 0, 0, -1);
      apply_model(d, stop_ok, par_ok, 0);
      tag = $sformatf("rnd%0d", i);
      check_state(tag);
      npop = $urandom_range(0, 2);
      for (int k = 0; k < npop; k++) begin
        if (model_q.size() != 0) pop_check(tag);
        else                     empty_read(tag);
      end
    end
    check_state("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
